// File: rtl/sop_truth_table_sweeper.sv
// Walks a 4-input function through all 16 vectors, captures its minterm mask and popcount.
// Optional golden-mask compare (mismatch/first_bad) is built when SOP_SWEEP_CHECK_EN is defined.
module sop_truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2
`ifdef SOP_SWEEP_CHECK_EN
  , parameter logic [15:0] EXPECTED_MASK = 16'hE188
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f_in,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] mask_out,
  output logic [4:0]  ones_count
`ifdef SOP_SWEEP_CHECK_EN
  , output logic        mismatch
  , output logic [3:0]  first_bad
`endif
);

  localparam logic [7:0] SC = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_e;

  state_e      state_q;
  logic [3:0]  idx_q, vec_q;
  logic [7:0]  cnt_q;
  logic        busy_q, done_q;
  logic [15:0] shadow_q, shadow_d, mask_q;
  logic [4:0]  ones_q;

  function automatic logic [4:0] popcnt(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction

  // Shadow including the bit being sampled this cycle, so the DONE load sees all 16 bits.
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[idx_q] = f_in;
  end

`ifdef SOP_SWEEP_CHECK_EN
  logic       mism_q;
  logic [3:0] fb_q;

  function automatic logic [3:0] lowest_diff(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shadow_q <= '0;
      mask_q   <= '0;
      ones_q   <= '0;
`ifdef SOP_SWEEP_CHECK_EN
      mism_q   <= 1'b0;
      fb_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          idx_q   <= '0;
          cnt_q   <= SC;
          vec_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            shadow_q <= shadow_d;
            if (idx_q == 4'd15) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              mask_q  <= shadow_d;
              ones_q  <= popcnt(shadow_d);
`ifdef SOP_SWEEP_CHECK_EN
              mism_q  <= (shadow_d != EXPECTED_MASK);
              fb_q    <= lowest_diff(shadow_d ^ EXPECTED_MASK);
`endif
            end else begin
              idx_q <= idx_q + 4'd1;
              vec_q <= idx_q + 4'd1;
              cnt_q <= SC;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          vec_q   <= '0;
          idx_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {A, B, C, D} = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign mask_out   = mask_q;
  assign ones_count = ones_q;
`ifdef SOP_SWEEP_CHECK_EN
  assign mismatch   = mism_q;
  assign first_bad  = fb_q;
`endif

endmodule

// File: tb/tb_sop_truth_table_sweeper.sv
// Bench for sop_truth_table_sweeper: two instances (SETTLE_CYCLES=2 and 0) driven by truth tables.
module tb_sop_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st0 = 1'b0, st1 = 1'b0;
  logic [15:0] tt [2];

  logic A0, B0, C0, D0, busy0, done0, f0;
  logic A1, B1, C1, D1, busy1, done1, f1;
  logic [15:0] mask0, mask1;
  logic [4:0]  ones0, ones1;
  logic [3:0]  v0, v1;
  logic        mism0, mism1;
  logic [3:0]  fb0, fb1;

  assign v0 = {A0, B0, C0, D0};
  assign v1 = {A1, B1, C1, D1};
  assign f0 = tt[0][v0];
  assign f1 = tt[1][v1];

`ifndef SOP_SWEEP_CHECK_EN
  assign mism0 = 1'b0;
  assign mism1 = 1'b0;
  assign fb0   = 4'd0;
  assign fb1   = 4'd0;
`endif

  sop_truth_table_sweeper #(.SETTLE_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .start(st0), .f_in(f0),
    .A(A0), .B(B0), .C(C0), .D(D0), .busy(busy0), .done(done0),
    .mask_out(mask0), .ones_count(ones0)
`ifdef SOP_SWEEP_CHECK_EN
    , .mismatch(mism0), .first_bad(fb0)
`endif
  );

  sop_truth_table_sweeper #(.SETTLE_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .start(st1), .f_in(f1),
    .A(A1), .B(B1), .C(C1), .D(D1), .busy(busy1), .done(done1),
    .mask_out(mask1), .ones_count(ones1)
`ifdef SOP_SWEEP_CHECK_EN
    , .mismatch(mism1), .first_bad(fb1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Behavioural model: m_t = cycles since the accepting edge (0 = idle); DONE is cycle 16*P+1.
  int          m_t [2];
  logic [15:0] m_mask [2];
  localparam logic [15:0] GOLD = 16'hE188;

  function automatic int per_vec(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin m_t[k] = 0; m_mask[k] = '0; end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_t[k] == 0) begin
          if ((k == 0) ? st0 : st1) m_t[k] = 1;
        end else if (m_t[k] == 16 * per_vec(k) + 1) begin
          m_t[k] = 0;
        end else begin
          m_t[k]++;
          if (m_t[k] == 16 * per_vec(k) + 1) m_mask[k] = tt[k];
        end
      end
    end
  end

  function automatic int exp_vec(input int k);
    if (m_t[k] == 0) return 0;
    if (m_t[k] == 16 * per_vec(k) + 1) return 15;
    return (m_t[k] - 1) / per_vec(k);
  endfunction

  function automatic int exp_fb(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i] != GOLD[i]) return i;
    return 0;
  endfunction

  task automatic cmp(input int k, input logic b, input logic d, input logic [3:0] v,
                     input logic [15:0] m, input logic [4:0] o, input logic mi, input logic [3:0] fb);
    chk($sformatf("busy%0d", k), int'(b), int'(m_t[k] != 0));
    chk($sformatf("done%0d", k), int'(d), int'(m_t[k] == 16 * per_vec(k) + 1));
    chk($sformatf("vec%0d", k), int'(v), exp_vec(k));
    chk($sformatf("mask%0d", k), int'(m), int'(m_mask[k]));
    chk($sformatf("ones%0d", k), int'(o), $countones(m_mask[k]));
`ifdef SOP_SWEEP_CHECK_EN
    chk($sformatf("mismatch%0d", k), int'(mi), int'(m_mask[k] != GOLD));
    chk($sformatf("first_bad%0d", k), int'(fb), exp_fb(m_mask[k]));
`else
    if (mi || fb != 4'd0) chk("unused_check_ports", 1, 0);
`endif
  endtask

  always @(negedge clk) begin
    cmp(0, busy0, done0, v0, mask0, ones0, mism0, fb0);
    cmp(1, busy1, done1, v1, mask1, ones1, mism1, fb1);
  end

  task automatic run_sweep(input int k, output int lat);
    @(negedge clk);
    if (k == 0) st0 = 1'b1; else st1 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0; st1 = 1'b0;
    lat = 1;
    while (!((k == 0) ? done0 : done1) && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat, nb, extra;

  initial begin
    tt[0] = '0;
    tt[1] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_vec", int'(v0), 0);
    chk("rst_mask", int'(mask0), 0);
    rst = 1'b0;

    // Reference function, minterms {3,7,8,13,14,15}
    tt[0] = 16'hE188;
    run_sweep(0, lat);
    chk("lat_s2", lat, 49);
    chk("mask_e188", int'(mask0), 16'hE188);
    chk("ones_e188", int'(ones0), 6);
`ifdef SOP_SWEEP_CHECK_EN
    chk("mism_e188", int'(mism0), 0);
    chk("fb_e188", int'(fb0), 0);
`endif

    // f tied 0, with extra starts at cycle 5 and in the DONE cycle
    repeat (2) @(negedge clk);
    tt[0] = 16'h0000;
    @(negedge clk); st0 = 1'b1;
    @(posedge clk); #1; st0 = 1'b0;
    lat = 1; nb = 0;
    while (!done0 && lat < 400) begin
      if (busy0) nb++;
      st0 = (lat == 5);
      @(posedge clk); #1;
      lat++;
    end
    if (busy0) nb++;
    st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    chk("lat_tied0", lat, 49);
    chk("busy_cycles", nb, 49);
    chk("post_done_vec", int'(v0), 0);
    chk("post_done_busy", int'(busy0), 0);
    extra = 0;
    repeat (60) begin @(posedge clk); #1; if (done0 || busy0) extra++; end
    chk("no_restart", extra, 0);
    chk("mask_zero", int'(mask0), 0);
    chk("ones_zero", int'(ones0), 0);

    // Random function, then a sweep aborted by reset at cycle 20
    tt[0] = 16'($urandom);
    run_sweep(0, lat);
    chk("mask_rand", int'(mask0), int'(tt[0]));
    repeat (2) @(negedge clk);
    tt[0] = 16'($urandom);
    @(negedge clk); st0 = 1'b1;
    @(posedge clk); #1; st0 = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_vec", int'(v0), 0);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_done", int'(done0), 0);
    chk("abort_mask", int'(mask0), 0);
    chk("abort_ones", int'(ones0), 0);
    @(negedge clk); rst = 1'b0;
    tt[0] = 16'hE188;
    run_sweep(0, lat);
    chk("lat_after_rst", lat, 49);
    chk("mask_after_rst", int'(mask0), 16'hE188);

    // SETTLE_CYCLES=0 instance
    tt[1] = 16'hFFFF;
    run_sweep(1, lat);
    chk("lat_s0", lat, 17);
    chk("mask_ffff", int'(mask1), 16'hFFFF);
    chk("ones_ffff", int'(ones1), 16);
    for (int n = 0; n < 4; n++) begin
      repeat (2) @(negedge clk);
      tt[1] = 16'($urandom);
      run_sweep(1, lat);
      chk("lat_s0_rand", lat, 17);
    end

    for (int n = 0; n < 4; n++) begin
      repeat (2) @(negedge clk);
      tt[0] = 16'($urandom);
      run_sweep(0, lat);
      chk("lat_s2_rand", lat, 49);
    end

`ifdef SOP_SWEEP_CHECK_EN
    repeat (2) @(negedge clk);
    tt[0] = 16'hE088;
    run_sweep(0, lat);
    chk("mask_e088", int'(mask0), 16'hE088);
    chk("mism_e088", int'(mism0), 1);
    chk("fb_e088", int'(fb0), 8);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
